// File: rtl/sprite_sched_pkg.sv
// Shared types and constants for the sprite update scheduler.
// Entries carry {index, value}; control bits are decoded from the control register write data.
package sprite_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } sched_state_t;

  localparam logic [11:0] CONTROL_INDEX_DEFAULT = 12'hFFF;
  localparam int          CTRL_CLR_OVF          = 0;
  localparam int          CTRL_FORCE            = 1;
  localparam int          ENTRY_W               = 28;

  typedef struct packed {
    logic [11:0] index;
    logic [15:0] value;
  } entry_t;

endpackage

// File: rtl/sched_fifo.sv
// First-word-fall-through FIFO of register-write entries; head is valid whenever !empty.
// Pushes while full are ignored (even with a same-cycle pop); pops while empty are ignored.
module sched_fifo
  import sprite_sched_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  entry_t        data,
  output entry_t        head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push & ~do_pop)      count <= count + 1'b1;
      else if (do_pop & ~do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/sprite_update_scheduler.sv
// Buffers CPU register writes and replays them only in vblank (or on a forced drain); replay >= 2 cycles after push.
// cpu_ready_o drops when the FIFO is full; writes made anyway are dropped and flagged in overflow_o.
module sprite_update_scheduler
  import sprite_sched_pkg::*;
#(
  parameter int          FIFO_DEPTH    = 16,
  parameter int          FIFO_AW       = 4,
  parameter logic [11:0] CONTROL_INDEX = CONTROL_INDEX_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cpu_write_i,
  input  logic [11:0]        cpu_index_i,
  input  logic [15:0]        cpu_value_i,
  output logic               cpu_ready_o,
  input  logic               in_vblank_i,
  output logic               reg_write_o,
  output logic [11:0]        reg_index_o,
  output logic [15:0]        reg_value_o,
  output logic [FIFO_AW:0]   pending_o,
  output logic               overflow_o,
  output logic               draining_o,
  output logic [15:0]        frame_count_o
);

  sched_state_t     state;
  sched_state_t     state_nxt;
  logic             vblank_latched;
  logic             vb_rise;
  logic             force_pending;
  logic             force_pending_nxt;
  logic             drain_forced;
  logic             drain_forced_nxt;
  logic             is_ctrl;
  logic             is_data;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FIFO_AW:0] fifo_count;
  entry_t           wr_entry;
  entry_t           head_entry;

  assign vb_rise  = in_vblank_i & ~vblank_latched;
  assign is_ctrl  = cpu_write_i & (cpu_index_i == CONTROL_INDEX);
  assign is_data  = cpu_write_i & ~is_ctrl;
  assign push     = is_data & ~fifo_full;
  assign wr_entry = '{index: cpu_index_i, value: cpu_value_i};

  sched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .data    (wr_entry),
    .head    (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_nxt         = state;
    drain_forced_nxt  = drain_forced;
    force_pending_nxt = force_pending;
    pop               = 1'b0;
    case (state)
      IDLE: begin
        if ((vb_rise | force_pending) & ~fifo_empty) begin
          state_nxt        = DRAIN;
          drain_forced_nxt = force_pending;
        end
        force_pending_nxt = 1'b0;
      end
      DRAIN: begin
        // An unforced drain stops as soon as vblank ends; leftovers wait for the next frame.
        if ((~in_vblank_i & ~drain_forced) | fifo_empty) begin
          state_nxt = IDLE;
        end else begin
          pop = 1'b1;
          if ((fifo_count == (FIFO_AW+1)'(1)) & ~push) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (is_ctrl & cpu_value_i[CTRL_FORCE]) force_pending_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      vblank_latched <= 1'b0;
      force_pending  <= 1'b0;
      drain_forced   <= 1'b0;
      overflow_o     <= 1'b0;
      frame_count_o  <= '0;
      reg_write_o    <= 1'b0;
      reg_index_o    <= '0;
      reg_value_o    <= '0;
    end else begin
      state          <= state_nxt;
      vblank_latched <= in_vblank_i;
      force_pending  <= force_pending_nxt;
      drain_forced   <= drain_forced_nxt;
      if (is_data & fifo_full)                      overflow_o <= 1'b1;
      else if (is_ctrl & cpu_value_i[CTRL_CLR_OVF]) overflow_o <= 1'b0;
      if (vb_rise) frame_count_o <= frame_count_o + 16'd1;
      reg_write_o <= pop;
      if (pop) begin
        reg_index_o <= head_entry.index;
        reg_value_o <= head_entry.value;
      end
    end
  end

  assign draining_o  = (state == DRAIN);
  assign pending_o   = fifo_count;
  assign cpu_ready_o = ~fifo_full;

endmodule

// File: doc/sprite_update_scheduler.md
Name: sprite_update_scheduler

Overview:
- Buffers CPU writes to display/sprite registers in a FIFO and replays them to the display controller only during vertical blanking, so sprite position/shape changes never tear mid-frame.
- Sits between the CPU register-write bus and the display controller's register_write/register_index/register_write_value inputs.
- Also keeps a frame counter and a sticky overflow flag for software pacing.

Parameters:
- FIFO_DEPTH, 16, number of buffered writes (power of two, 2..256).
- FIFO_AW, 4, log2(FIFO_DEPTH).
- CONTROL_INDEX, 12'hFFF, register index decoded locally as the control register and never enqueued.

Ports:
- clk  input  1  system clock; all state on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- cpu_write_i  input  1  CPU write strobe, one write per cycle.
- cpu_index_i  input  12  CPU register index.
- cpu_value_i  input  16  CPU write data.
- cpu_ready_o  output  1  high when FIFO not full.
- in_vblank_i  input  1  vblank level from the display controller.
- reg_write_o  output  1  replayed write strobe to the display controller.
- reg_index_o  output  12  replayed index.
- reg_value_o  output  16  replayed data.
- pending_o  output  FIFO_AW+1  current FIFO occupancy.
- overflow_o  output  1  sticky: a write was dropped.
- draining_o  output  1  high while in DRAIN.
- frame_count_o  output  16  vblank rising edges since reset; wraps.

Behaviour:
- Reset (async, reset_n low): FIFO empty, state IDLE, reg_write_o=0, reg_index_o=0, reg_value_o=0, pending_o=0, overflow_o=0, draining_o=0, frame_count_o=0, cpu_ready_o=1, vblank_latched=0, force_pending=0.
- vblank edge: vblank_latched <= in_vblank_i each cycle; vb_rise = in_vblank_i & ~vblank_latched.
- frame_count_o increments on vb_rise; 16'hFFFF wraps to 0.
- Enqueue: on cpu_write_i with cpu_index_i != CONTROL_INDEX, push {index,value} if not full.
- Full FIFO: the write is dropped and overflow_o is set, even if a pop occurs in the same cycle.
- Simultaneous push and pop: both take effect and occupancy is unchanged.
- Control write (cpu_index_i == CONTROL_INDEX):
  - bit0=1: clears overflow_o. If an overflow occurs in the same cycle, set wins.
  - bit1=1: sets force_pending, requesting a drain regardless of vblank.
  - Never enqueued; cpu_ready_o does not gate it.
- State machine:
  - IDLE:
    - (vb_rise & !empty) or (force_pending & !empty) -> DRAIN; force_pending clears on the transition.
    - force_pending with an empty FIFO clears with no transition.
  - DRAIN: one pop per cycle.
    - Exit to IDLE when the pop empties the FIFO and no push occurs that cycle.
    - Exit to IDLE when in_vblank_i is low and the drain was not forced. The cycle vblank is seen low performs no pop; remaining entries wait for the next vb_rise.
    - A forced drain runs until empty, ignoring vblank.
    - Entries pushed during DRAIN are drained in the same window.
- Output timing:
  - reg_write_o/reg_index_o/reg_value_o are registered; the strobe is asserted the cycle after the pop, for exactly one cycle per entry.
  - reg_index_o/reg_value_o hold their last value when the strobe is low.
  - FIFO order is strictly preserved.
- Latency: CPU write to replay is minimum 2 cycles (push, then pop in DRAIN, then registered output), otherwise bounded by the next vblank.
- draining_o = (state==DRAIN). pending_o and cpu_ready_o are registered from the FIFO count.
- Reset mid-DRAIN: all buffered entries are discarded and no strobe is emitted after reset assertion.

Decomposition:
- Shared package sprite_sched_pkg:
  - state encoding IDLE/DRAIN;
  - CONTROL_INDEX default;
  - control bit positions CTRL_CLR_OVF=0, CTRL_FORCE=1;
  - entry width constant 28.
- One sub-module, sched_fifo: synchronous FIFO with async active-low reset, 28-bit entries.
  - Inputs: push, pop, data.
  - Outputs: head data, full, empty, count.
  - Reads are combinational head (first-word fall-through).

Test Plan:
- Reset, then 3 writes (idx 3/4/5, values 10/20/30) with in_vblank_i=0 -> pending_o=3, no reg_write_o; raise vblank -> strobes on 3 consecutive cycles in order, starting 2 cycles after the edge; pending_o=0; frame_count_o=1.
- Fill 16 entries, write a 17th -> cpu_ready_o=0, overflow_o=1, 17th never replayed; control write 16'h0001 -> overflow_o=0.
- 10 entries queued, vblank held high for 4 cycles -> exactly 3 or 4 replays (entries 0..n in order), remainder replayed after the next vb_rise, frame_count_o=2.
- Vblank low, 2 entries queued, control write 16'h0002 -> both replayed immediately, draining_o high for 2 cycles; control write with an empty FIFO -> no strobe, force_pending cleared.
- During DRAIN, push idx 7 each cycle while popping -> occupancy constant, all entries replayed in order before exit.
- Assert reset_n low mid-DRAIN with 5 pending -> all outputs return to reset values asynchronously; after release, no strobe at the next vblank.
